// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem read at a time,
// pushes responses into the instruction queue and squashes responses made stale by a redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          ORDER_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  output logic [3:0]         imem_rmask,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_resp,
  output logic               instr_push,
  output logic [31:0]        instr_out,
  output logic [31:0]        instr_pc,
  output logic [ORDER_W-1:0] order_out,
  output logic [31:0]        pc_curr
);

  // state | meaning
  // READY | no request outstanding; may issue, take a redirect, or hold on stall
  // WAIT  | one request outstanding; its response will be pushed
  // DROP  | one request outstanding whose response is stale and must be discarded
  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc, pc_nxt;
  logic [ORDER_W-1:0] order, order_nxt;
  logic [31:0]        redirect_tgt;
  logic [3:0]         rmask_raw;
  logic               push_raw;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_READY;
      pc    <= RESET_PC;
      order <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      order <= order_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    order_nxt = order;
    rmask_raw = 4'h0;
    push_raw  = 1'b0;
    unique case (state)
      ST_READY: begin
        // A response here is a protocol error and is deliberately ignored.
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
        end else if (!fetch_stall) begin
          rmask_raw = 4'hF;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp) begin
          state_nxt = ST_READY;
          if (redirect_valid) begin
            pc_nxt = redirect_tgt;
          end else begin
            push_raw  = 1'b1;
            pc_nxt    = pc + 32'd4;
            order_nxt = order + {{(ORDER_W-1){1'b0}}, 1'b1};
          end
        end else if (redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (redirect_valid) pc_nxt = redirect_tgt;
        if (imem_resp) state_nxt = ST_READY;
      end
      default: state_nxt = ST_READY;
    endcase
  end

  // Gate strobes with reset so nothing is issued or pushed while reset is held.
  assign imem_rmask = rst ? rmask_raw : 4'h0;
  assign instr_push = rst & push_raw;
  assign imem_addr  = pc;
  assign instr_pc   = pc;
  assign pc_curr    = pc;
  assign order_out  = order;
  assign instr_out  = imem_rdata;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, async-reset sequences, then
// randomized traffic against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        instr_push;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [63:0] order_out;
  logic [31:0] pc_curr;

  int n_chk = 0;
  int n_err = 0;

  fetch_ctrl #(.RESET_PC(RST_PC), .ORDER_W(64)) dut (
    .clk(clk), .rst(rst), .fetch_stall(fetch_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .instr_push(instr_push), .instr_out(instr_out),
    .instr_pc(instr_pc), .order_out(order_out), .pc_curr(pc_curr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic [3:0]  e_rmask;
    logic        e_push;
    logic [31:0] e_pc;
    logic [63:0] e_order;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic resp, input logic [31:0] rdata, input logic [3:0] e_rmask,
                     input logic e_push, input logic [31:0] e_pc, input logic [63:0] e_order);
    vec_t v;
    v.stall = stall; v.redir = redir; v.rpc = rpc; v.resp = resp; v.rdata = rdata;
    v.e_rmask = e_rmask; v.e_push = e_push; v.e_pc = e_pc; v.e_order = e_order;
    vq.push_back(v);
  endtask

  // Called at a negedge: drive, settle, compare, then advance to the next negedge.
  task automatic step(input vec_t v, input string tag);
    fetch_stall    = v.stall;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    imem_resp      = v.resp;
    imem_rdata     = v.rdata;
    #1;
    chk({tag, " rmask"},     64'(imem_rmask), 64'(v.e_rmask));
    chk({tag, " push"},      64'(instr_push), 64'(v.e_push));
    chk({tag, " imem_addr"}, 64'(imem_addr),  64'(v.e_pc));
    chk({tag, " pc_curr"},   64'(pc_curr),    64'(v.e_pc));
    chk({tag, " instr_pc"},  64'(instr_pc),   64'(v.e_pc));
    chk({tag, " order"},     order_out,       v.e_order);
    if (v.e_push) chk({tag, " instr_out"}, 64'(instr_out), 64'(v.rdata));
    @(negedge clk);
  endtask

  // Reference model: whether a request is outstanding, whether it is stale,
  // and how many more cycles the memory waits before responding.
  logic [31:0] m_pc;
  logic [63:0] m_order;
  bit          m_busy, m_stale;
  int          m_wait;

  initial begin
    vec_t v;
    // Directed table
    add(0,0,0,0,0,            4'hF,0,32'h1eceb000,0);
    add(0,0,0,1,32'ha0,       4'h0,1,32'h1eceb000,0);
    add(0,0,0,0,0,            4'hF,0,32'h1eceb004,1);
    add(0,0,0,1,32'ha1,       4'h0,1,32'h1eceb004,1);
    add(0,0,0,0,0,            4'hF,0,32'h1eceb008,2);
    add(0,0,0,1,32'ha2,       4'h0,1,32'h1eceb008,2);
    for (int i = 0; i < 5; i++) add(1,0,0,0,0, 4'h0,0,32'h1eceb00c,3);
    add(0,0,0,0,0,            4'hF,0,32'h1eceb00c,3);
    add(0,0,0,1,32'ha3,       4'h0,1,32'h1eceb00c,3);
    add(0,0,0,0,0,            4'hF,0,32'h1eceb010,4);
    add(1,0,0,1,32'ha4,       4'h0,1,32'h1eceb010,4);
    add(1,0,0,0,0,            4'h0,0,32'h1eceb014,5);
    add(0,0,0,0,0,            4'hF,0,32'h1eceb014,5);
    add(0,1,32'h1003,0,0,     4'h0,0,32'h1eceb014,5);
    add(0,0,0,0,0,            4'h0,0,32'h00001000,5);
    add(0,0,0,0,0,            4'h0,0,32'h00001000,5);
    add(0,0,0,1,32'hdead,     4'h0,0,32'h00001000,5);
    add(0,0,0,0,0,            4'hF,0,32'h00001000,5);
    add(0,0,0,1,32'ha5,       4'h0,1,32'h00001000,5);
    add(0,0,0,0,0,            4'hF,0,32'h00001004,6);
    add(0,1,32'h5008,1,32'hbad,4'h0,0,32'h00001004,6);
    add(0,0,0,0,0,            4'hF,0,32'h00005008,6);
    add(0,0,0,1,32'ha6,       4'h0,1,32'h00005008,6);
    add(0,0,0,0,0,            4'hF,0,32'h0000500c,7);
    add(0,1,32'h1ff0,0,0,     4'h0,0,32'h0000500c,7);
    add(0,1,32'h2000,0,0,     4'h0,0,32'h00001ff0,7);
    add(0,1,32'h3000,0,0,     4'h0,0,32'h00002000,7);
    add(0,0,0,1,32'hbad,      4'h0,0,32'h00003000,7);
    add(0,0,0,0,0,            4'hF,0,32'h00003000,7);
    add(0,0,0,1,32'ha7,       4'h0,1,32'h00003000,7);
    add(0,1,32'hfffffffe,0,0, 4'h0,0,32'h00003004,8);
    add(0,0,0,0,0,            4'hF,0,32'hfffffffc,8);
    add(0,0,0,1,32'ha8,       4'h0,1,32'hfffffffc,8);
    add(0,0,0,0,0,            4'hF,0,32'h00000000,9);

    repeat (2) @(negedge clk);
    #1;
    chk("reset rmask", 64'(imem_rmask), 64'h0);
    chk("reset push",  64'(instr_push), 64'h0);
    chk("reset pc",    64'(pc_curr),    64'(RST_PC));
    chk("reset order", order_out,       64'h0);
    @(negedge clk);
    rst = 1'b1;
    foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

    // Now in WAIT with pc=0: asynchronous reset mid-cycle.
    #2 rst = 1'b0;
    #1;
    chk("async wait rmask", 64'(imem_rmask), 64'h0);
    chk("async wait pc",    64'(pc_curr),    64'(RST_PC));
    chk("async wait order", order_out,       64'h0);
    @(negedge clk);
    rst = 1'b1;
    v = '{0,0,0,0,0, 4'hF,0,RST_PC,0};
    step(v, "post-reset issue");
    // Reset asserted in a cycle where a request would otherwise be issued.
    v = '{0,0,0,1,32'hc0, 4'h0,1,RST_PC,0};
    step(v, "post-reset push");
    fetch_stall = 1'b0; redirect_valid = 1'b0; imem_resp = 1'b0;
    #1;
    chk("ready rmask pre", 64'(imem_rmask), 64'hF);
    #2 rst = 1'b0;
    #1;
    chk("async ready rmask", 64'(imem_rmask), 64'h0);
    chk("async ready pc",    64'(pc_curr),    64'(RST_PC));

    // Randomized traffic against the model.
    @(negedge clk);
    rst = 1'b1;
    m_pc = RST_PC; m_order = '0; m_busy = 0; m_stale = 0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      v.stall = ($urandom_range(0, 3) == 0);
      v.redir = ($urandom_range(0, 7) == 0);
      v.rpc   = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | 32'($urandom_range(0, 15))) : $urandom;
      v.resp  = m_busy && (m_wait == 0);
      v.rdata = $urandom;
      assert (!(v.resp && !m_busy)) else $error("bench drove imem_resp with no request outstanding");
      v.e_rmask = (!m_busy && !v.redir && !v.stall) ? 4'hF : 4'h0;
      v.e_push  = m_busy && v.resp && !v.redir && !m_stale;
      v.e_pc    = m_pc;
      v.e_order = m_order;
      step(v, $sformatf("rand%0d", c));
      tgt = v.rpc & ~32'd3;
      if (!m_busy) begin
        if (v.redir) m_pc = tgt;
        else if (!v.stall) begin
          m_busy = 1; m_stale = 0; m_wait = $urandom_range(0, 3);
        end
      end else if (v.resp) begin
        if (v.e_push) begin
          m_pc = m_pc + 32'd4;
          m_order = m_order + 64'd1;
        end else if (v.redir) m_pc = tgt;
        m_busy = 0;
      end else begin
        if (v.redir) begin
          m_pc = tgt; m_stale = 1;
        end
        m_wait--;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
